alu_share_arb: RTL

- Shares one instance of the team's combinational ALU module (ALU) among NUM_REQ requesters, for example the CPU execute stage and the DMA address generator.
- Round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Two-stage pipeline: issue register feeds the ALU; the ALU result lands in a response register.
- Responses carry the requester ID and are delivered in acceptance order.

---
 rtl/alu_arb_pkg.sv | 26 ++
 rtl/alu_share_arb_alu.sv | 50 +++++
 rtl/alu_share_arb_rr_arbiter.sv | 54 +++++
 rtl/alu_share_arb.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared opcode constants, issue payload type and counter helper for alu_share_arb.
package alu_arb_pkg;

    localparam logic [4:0] OP_RTYPE  = 5'b01100;
    localparam logic [4:0] OP_ITYPE  = 5'b00100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  func3;
        logic        func7;
        logic [31:0] op1;
        logic [31:0] op2;
    } alu_req_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/alu_share_arb_alu.sv
// Combinational RV32I-style ALU: integer ops, address adds, link values, branch compares.
module alu
    import alu_arb_pkg::*;
(
    input  alu_req_t    req,
    output logic [31:0] result
);

    logic [31:0] sra_s;
    logic [31:0] srl_s;

    // Decode opcode/func3 into one 32-bit result; anything unrecognised yields zero
    always_comb begin
        sra_s  = $signed(req.op1) >>> req.op2[4:0];
        srl_s  = req.op1 >> req.op2[4:0];
        result = 32'd0;
        case (req.opcode)
            OP_RTYPE, OP_ITYPE: begin
                case (req.func3)
                    3'b000:  result = (req.opcode == OP_RTYPE && req.func7) ? req.op1 - req.op2
                                                                            : req.op1 + req.op2;
                    3'b001:  result = req.op1 << req.op2[4:0];
                    3'b010:  result = {31'd0, $signed(req.op1) < $signed(req.op2)};
                    3'b011:  result = {31'd0, req.op1 < req.op2};
                    3'b100:  result = req.op1 ^ req.op2;
                    3'b101:  result = req.func7 ? sra_s : srl_s;
                    3'b110:  result = req.op1 | req.op2;
                    3'b111:  result = req.op1 & req.op2;
                    default: result = 32'd0;
                endcase
            end
            OP_LUI:                      result = req.op2;
            OP_AUIPC, OP_LOAD, OP_STORE: result = req.op1 + req.op2;
            OP_JAL, OP_JALR:             result = req.op1 + 32'd4;
            OP_BRANCH: begin
                case (req.func3)
                    3'b000:  result = {31'd0, req.op1 == req.op2};
                    3'b001:  result = {31'd0, req.op1 != req.op2};
                    3'b100:  result = {31'd0, $signed(req.op1) < $signed(req.op2)};
                    3'b101:  result = {31'd0, $signed(req.op1) >= $signed(req.op2)};
                    3'b110:  result = {31'd0, req.op1 < req.op2};
                    3'b111:  result = {31'd0, req.op1 >= req.op2};
                    default: result = 32'd0;
                endcase
            end
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from rr_ptr; pointer moves past winner on advance.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] rr_ptr_r;
    logic [PW-1:0] winner_s;
    logic [PW-1:0] next_ptr_s;
    logic [PW-1:0] idx_s;
    logic [PW:0]   sum_s;
    logic          found_s;
    logic          hit_s;

    // Wrap-around priority scan; first set request at or above rr_ptr wins
    always_comb begin
        grant    = '0;
        winner_s = '0;
        found_s  = 1'b0;
        hit_s    = 1'b0;
        sum_s    = '0;
        idx_s    = '0;
        for (int off = 0; off < N; off++) begin
            sum_s         = {1'b0, rr_ptr_r} + (PW+1)'(off);
            sum_s         = (sum_s >= (PW+1)'(N)) ? sum_s - (PW+1)'(N) : sum_s;
            idx_s         = sum_s[PW-1:0];
            hit_s         = !found_s && req[idx_s];
            grant[idx_s]  = grant[idx_s] | hit_s;
            winner_s      = hit_s ? idx_s : winner_s;
            found_s       = found_s | hit_s;
        end
    end

    assign next_ptr_s = (winner_s == PW'(N - 1)) ? '0 : winner_s + PW'(1);

    // Pointer register: only an accepted request moves priority on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (advance) begin
            rr_ptr_r <= next_ptr_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// One ALU shared by NUM_REQ requesters through a round-robin arbiter and a two-stage pipeline.
// Optional performance counters are enabled with `define ALU_SHARE_ARB_PERF_EN.
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*5-1:0]  req_opcode,
    input  logic [NUM_REQ*3-1:0]  req_func3,
    input  logic [NUM_REQ-1:0]    req_func7,
    input  logic [NUM_REQ*32-1:0] req_op1,
    input  logic [NUM_REQ*32-1:0] req_op2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0] perf_grant_cnt,
    output logic [31:0]           perf_conflict_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    logic [NUM_REQ-1:0] grant_s;
    logic               s2_load_s;
    logic               s1_free_s;
    logic               accept_s;
    alu_req_t           sel_req_s;
    logic [ID_W-1:0]    sel_id_s;
    logic [31:0]        alu_result_s;

    logic               s1_valid_r;
    logic [ID_W-1:0]    s1_id_r;
    alu_req_t           s1_req_r;
    logic               rsp_valid_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic [31:0]        rsp_data_r;

    assign s2_load_s = s1_valid_r && (!rsp_valid_r || rsp_ready);
    assign s1_free_s = !s1_valid_r || s2_load_s;
    // rst_n gates ready so nothing is accepted while reset is held
    assign req_ready = grant_s & {NUM_REQ{s1_free_s && !flush && rst_n}};
    assign accept_s  = |req_ready;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (accept_s),
        .grant   (grant_s)
    );

    // AND-OR mux of the one-hot winner's request fields
    always_comb begin
        sel_req_s = '0;
        sel_id_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_req_s.opcode |= req_opcode[i*5 +: 5]  & {5{grant_s[i]}};
            sel_req_s.func3  |= req_func3[i*3 +: 3]   & {3{grant_s[i]}};
            sel_req_s.func7  |= req_func7[i]          & grant_s[i];
            sel_req_s.op1    |= req_op1[i*32 +: 32]   & {32{grant_s[i]}};
            sel_req_s.op2    |= req_op2[i*32 +: 32]   & {32{grant_s[i]}};
            sel_id_s         |= ID_W'(i)              & {ID_W{grant_s[i]}};
        end
    end

    alu u_alu (
        .req    (s1_req_r),
        .result (alu_result_s)
    );

    // Issue register: loads on accept, empties when its entry moves to S2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_id_r    <= '0;
            s1_req_r   <= '0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_id_r    <= sel_id_s;
            s1_req_r   <= sel_req_s;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Response register: holds id/data stable while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_data_r  <= 32'd0;
        end else if (flush) begin
            rsp_valid_r <= 1'b0;
        end else if (s2_load_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= s1_id_r;
            rsp_data_r  <= alu_result_s;
        end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;

`ifdef ALU_SHARE_ARB_PERF_EN
    logic multi_req_s;
    assign multi_req_s = $countones(req_valid) > 32'sd1;

    // Saturating event counters; only rst_n clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant_cnt    <= '0;
            perf_conflict_cnt <= 32'd0;
            perf_stall_cnt    <= 32'd0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                perf_grant_cnt[i*32 +: 32] <= req_ready[i] ? sat_inc(perf_grant_cnt[i*32 +: 32])
                                                           : perf_grant_cnt[i*32 +: 32];
            end
            perf_conflict_cnt <= multi_req_s ? sat_inc(perf_conflict_cnt) : perf_conflict_cnt;
            perf_stall_cnt    <= (s1_valid_r && !s2_load_s) ? sat_inc(perf_stall_cnt) : perf_stall_cnt;
        end
    end
`endif

endmodule
